// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator (640x480@60 by default).
// Ports: clk/rst_n in; hpos/vpos raster position; hsync/vsync, display_on,
//   line_start, frame_start decodes; frame_no frame index. All outputs registered and aligned.
// Latency: decodes are loaded from the next-state counters, so they always describe
//   the hpos/vpos presented in the same cycle. No handshake; the block never stalls.
module vga_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int FRAME_BITS = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [9:0]            hpos,
   output logic [9:0]            vpos,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  display_on,
   output logic                  line_start,
   output logic                  frame_start,
   output logic [FRAME_BITS-1:0] frame_no
);

   // Both totals must not exceed 1024 so the 10-bit counters can hold them.
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   // Window bounds compared at 11 bits: a sync window ending exactly at 1024
   // (zero back porch) must not wrap to 0.
   localparam logic [10:0] H_DISP_END   = 11'(H_DISPLAY);
   localparam logic [10:0] H_SYNC_START = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] H_SYNC_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] V_DISP_END   = 11'(V_DISPLAY);
   localparam logic [10:0] V_SYNC_START = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] V_SYNC_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

   localparam logic [FRAME_BITS-1:0] FRAME_ONE = FRAME_BITS'(1);

   logic [9:0]  h_nxt;
   logic [9:0]  v_nxt;
   logic [10:0] h_ext;
   logic [10:0] v_ext;
   logic        hs_act_nxt;
   logic        vs_act_nxt;
   logic        de_nxt;
   logic        ls_nxt;
   logic        fs_nxt;

   // Next raster position; the reset state (last position) makes the first
   // edge after release land on (0,0) through the ordinary wrap path.
   always_comb begin
      h_nxt = hpos + 10'd1;
      v_nxt = vpos;
      if (hpos == H_LAST) begin
         h_nxt = 10'd0;
         v_nxt = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
      end
   end

   assign h_ext      = {1'b0, h_nxt};
   assign v_ext      = {1'b0, v_nxt};
   assign hs_act_nxt = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
   assign vs_act_nxt = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);
   assign de_nxt     = (h_ext < H_DISP_END) && (v_ext < V_DISP_END);
   assign ls_nxt     = (h_nxt == 10'd0);
   assign fs_nxt     = (h_nxt == 10'd0) && (v_nxt == 10'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hpos        <= H_LAST;
         vpos        <= V_LAST;
         hsync       <= ~H_SYNC_POL;
         vsync       <= ~V_SYNC_POL;
         display_on  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_no    <= '1;     // first frame_start rolls this over to frame 0
      end else begin
         hpos        <= h_nxt;
         vpos        <= v_nxt;
         hsync       <= hs_act_nxt ? H_SYNC_POL : ~H_SYNC_POL;
         vsync       <= vs_act_nxt ? V_SYNC_POL : ~V_SYNC_POL;
         display_on  <= de_nxt;
         line_start  <= ls_nxt;
         frame_start <= fs_nxt;
         if (fs_nxt) begin
            frame_no <= frame_no + FRAME_ONE;
         end
      end
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator for the 640x480@60 Hz pattern top level, running on the 25.175 MHz pixel clock. It produces the aligned pixel coordinates, sync pulses, display-enable and frame/line strobes that the colour and frame-counting logic downstream consumes. Its frame counter replaces ad-hoc vsync edge detection in consumers. All outputs are registered and mutually aligned, with no combinational decode on the output pins.

## Interface

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, active level of hsync
- V_SYNC_POL, 0, active level of vsync
- FRAME_BITS, 9, width of frame_no

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_SYNC_POL
- vsync  out  1  vertical sync, level per V_SYNC_POL
- display_on  out  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY
- line_start  out  1  one-cycle strobe when hpos == 0
- frame_start  out  1  one-cycle strobe when hpos == 0 and vpos == 0
- frame_no  out  FRAME_BITS  frame index, increments at each frame_start

## Operation

- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525 by default).
  - Both totals must be ≤ 1024.
- Counter advance, every clock:
  - hpos increments.
  - At hpos == H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - At vpos == V_TOTAL-1 with hpos wrapping, vpos also wraps to 0.
- hsync is active while H_DISPLAY+H_FRONT ≤ hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751 by default); inactive level is ~H_SYNC_POL.
- vsync is active for every clock while V_DISPLAY+V_FRONT ≤ vpos < V_DISPLAY+V_FRONT+V_SYNC (lines 490..491), independent of hpos.
- Decoded outputs (hsync, vsync, display_on, line_start, frame_start) are registers loaded from the next-state counter values, so they always describe the hpos/vpos presented in the same cycle.
- frame_no increments by 1 (modulo 2^FRAME_BITS) on the clock that loads (0,0). It wraps from all-ones to 0 silently.
- Reset values, applied asynchronously:
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1 (the last raster position).
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL.
  - display_on = 0, line_start = 0, frame_start = 0.
  - frame_no = all-ones.
  - These values are self-consistent with the decode rules.
- First rising edge after reset release loads hpos = 0, vpos = 0, display_on = 1, line_start = 1, frame_start = 1, frame_no = 0. The first displayed frame is therefore frame 0.
- Reset asserted mid-frame forces the reset values immediately, without waiting for a clock. Resumption follows the first-edge rule above.

## Timing

- Zero cycles of skew between hpos/vpos and every decoded output. Consumers that add one register stage keep that alignment.
- Line period: H_TOTAL clocks. Frame period: H_TOTAL·V_TOTAL clocks (420 000 by default).
- hsync pulse: H_SYNC consecutive clocks per line, with the first active clock at hpos == 656.
- vsync pulse: V_SYNC·H_TOTAL consecutive clocks (1600 by default), from (hpos 0, vpos 490) to (hpos 799, vpos 491).
- line_start and frame_start are high for exactly one clock. frame_start implies line_start.
- No input handshake; the block never stalls.

## Test plan

- Reset: hold rst_n low with clk running -> hpos = 799, vpos = 524, hsync = vsync = 1, display_on = line_start = frame_start = 0, frame_no = 511. After release, first edge -> (0,0), display_on = 1, both strobes = 1, frame_no = 0.
- Line timing: from (0,0), count 800 clocks -> hsync low exactly on hpos 656..751 (96 clocks), line_start high only at hpos 0, vpos = 1 at clock 800.
- Frame timing: run one full frame -> vsync low for exactly 1600 clocks starting at vpos 490, hpos 0. display_on high for exactly 307 200 clocks. The next frame_start arrives 420 000 clocks after the first, with frame_no = 1.
- Wrap: run 512 frames (or force via a reduced-parameter build with V_TOTAL, H_TOTAL small) -> frame_no goes 511 -> 0 at frame_start with no glitch on other outputs.
- Mid-frame reset: assert rst_n low at (hpos 700, vpos 200) between clock edges -> all outputs take their reset values immediately. Release -> sequence restarts at (0,0) with frame_no = 0.
- Polarity: build with H_SYNC_POL = 1, V_SYNC_POL = 1 -> reset levels hsync = vsync = 0, pulses high over the same windows as above.
